// File: rtl/spi_mux_master.sv
// SPI mode-0 master for 16-bit SPI_Slave mux-bus command frames (rw, ext addr, reg addr, data).
// Define SPI_MUX_MASTER_READ_EN to support read frames; otherwise every frame is a write and rdata is 0.
`timescale 1ns/1ps
module spi_mux_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [2:0] ext_addr,
  input  logic [2:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic       miso,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

`ifdef SPI_MUX_MASTER_READ_EN
  localparam logic READ_SUPPORT = 1'b1;
`else
  localparam logic READ_SUPPORT = 1'b0;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  half_q, half_d;
  logic [15:0] shreg_q, shreg_d;
  logic        rd_q, rd_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] frame;
  logic        rd_req;
  logic        div_end;

  assign rd_req  = rw & READ_SUPPORT;
  assign div_end = (div_q == DIV_LAST);

  // frame[k] is the k-th bit on the wire; data goes out MSB first
  always_comb begin
    frame      = '0;
    frame[0]   = rd_req;
    frame[3:1] = ext_addr;
    frame[7:5] = reg_addr;
    for (int unsigned i = 0; i < 8; i++) begin
      frame[8 + i] = rd_req ? 1'b0 : wdata[7 - i];
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    shreg_d = shreg_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        cs_d   = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = LEAD;
          shreg_d = frame;
          rd_d    = rd_req;
          div_d   = '0;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          mosi_d  = frame[0];
        end
      end
      LEAD: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d  = '0;
          half_d = half_q + 5'd1;
          // Even half-periods are high: ending one is a falling edge, ending an odd one a rise.
          if (!half_q[0]) begin
            sclk_d = 1'b0;
            if (half_q != 5'd30) begin
              shreg_d = {shreg_q[0], shreg_q[15:1]};
              mosi_d  = shreg_q[1];
            end
          end else if (half_q == 5'd31) begin
            state_d = TRAIL;
          end else begin
            sclk_d = 1'b1;
            if (rd_q && half_q >= 5'd15) begin
              rdata_d = {rdata_q[6:0], miso};
            end
          end
        end
      end
      TRAIL: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          cs_d    = 1'b0;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      shreg_q <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      shreg_q <= shreg_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk  = sclk_q;
  assign cs    = cs_q;
  assign mosi  = mosi_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;

endmodule
